// File: rtl/ofdm_rx_pkg.sv
// rtl/ofdm_rx_pkg.sv - shared types and constants for the Viterbi stream controller
package ofdm_rx_pkg;

  localparam int SOFT_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Mid-scale soft value: carries no confidence toward either bit value.
  function automatic logic [7:0] neutral_soft(input int soft_w);
    return 8'((1 << (soft_w - 1)) - 1);
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// rtl/pair_fifo.sv - synchronous show-ahead FIFO for soft-bit pairs
module pair_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    full     = (count == (AW+1)'(DEPTH));
    empty    = (count == '0);
    pop_data = mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (enable) begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (enable && !clear && !reset && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/viterbi_stream_ctrl.sv
// rtl/viterbi_stream_ctrl.sv - feeds soft pairs to a Viterbi decoder and packs decoded bits into bytes
module viterbi_stream_ctrl
  import ofdm_rx_pkg::*;
#(
  parameter int SOFT_W     = SOFT_W_DEFAULT,
  parameter int FIFO_DEPTH = 16,
  parameter int SKIP_BITS  = 9
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  input  logic [31:0]         num_bits_to_decode,
  input  logic                do_descramble,
  input  logic [2*SOFT_W-1:0] in_data,
  input  logic [1:0]          in_erase,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [15:0]         vit_tdata,
  output logic [7:0]          vit_tuser,
  output logic                vit_tvalid,
  input  logic                vit_tready,
  input  logic                dec_bit,
  input  logic                dec_bit_valid,
  input  logic                desc_bit,
  input  logic                desc_bit_valid,
  output logic [7:0]          byte_out,
  output logic                byte_out_strobe,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  localparam int         PAIR_W  = 2*SOFT_W + 2;
  localparam logic [7:0] NEUTRAL = neutral_soft(SOFT_W);

  state_t            state;
  logic [31:0]       nbits;
  logic [31:0]       coded_cnt;
  logic [31:0]       coded_next;
  logic [31:0]       out_cnt;
  logic              desc_mode;
  logic [15:0]       skip_cnt;
  logic [2:0]        fill;
  logic [7:0]        pack;
  logic [7:0]        pack_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              vit_fire;
  logic              bit_take;
  logic              bit_val;
  logic              last_bit;
  logic [PAIR_W-1:0] head;

  pair_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pair_fifo (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .clear     (start),
    .push      (push),
    .push_data ({in_erase, in_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    in_ready   = (state == ST_FEED && !fifo_full) || (state == ST_FLUSH);
    vit_tvalid = (state == ST_FEED && !fifo_empty) || (state == ST_FLUSH);
    busy       = (state != ST_IDLE);
    vit_fire   = vit_tvalid && vit_tready && !start;
    push       = (state == ST_FEED) && in_valid && !fifo_full && !start;
    pop        = vit_fire && (state == ST_FEED);
    coded_next = (coded_cnt > 32'hFFFF_FFFD) ? 32'hFFFF_FFFF : coded_cnt + 32'd2;
    bit_take   = (state != ST_IDLE) && (desc_mode ? desc_bit_valid : dec_bit_valid);
    bit_val    = desc_mode ? desc_bit : dec_bit;
    pack_next  = pack | (8'(bit_val) << fill);
    last_bit   = ((out_cnt + 32'd1) == nbits);
    vit_tdata  = '0;
    vit_tuser  = '0;
    if (state == ST_FLUSH) begin
      vit_tdata = {NEUTRAL, NEUTRAL};
    end else if (state == ST_FEED && !fifo_empty) begin
      vit_tdata = {8'(head[2*SOFT_W-1:SOFT_W]), 8'(head[SOFT_W-1:0])};
      vit_tuser = {6'b0, head[PAIR_W-1:PAIR_W-2]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      nbits           <= '0;
      desc_mode       <= 1'b0;
      coded_cnt       <= '0;
      out_cnt         <= '0;
      skip_cnt        <= 16'(SKIP_BITS);
      fill            <= '0;
      pack            <= '0;
      byte_out        <= '0;
      byte_out_strobe <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
    end else if (enable) begin
      done            <= 1'b0;
      byte_out_strobe <= 1'b0;
      if (in_valid && !in_ready) overflow <= 1'b1;
      if (start) begin
        nbits     <= num_bits_to_decode;
        desc_mode <= do_descramble;
        coded_cnt <= '0;
        out_cnt   <= '0;
        skip_cnt  <= 16'(SKIP_BITS);
        fill      <= '0;
        pack      <= '0;
        overflow  <= 1'b0;
        if (num_bits_to_decode == 32'd0) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end else begin
          state <= ST_FEED;
        end
      end else begin
        if (vit_fire) begin
          coded_cnt <= coded_next;
          if (state == ST_FEED && coded_next >= nbits) state <= ST_FLUSH;
        end
        // Bit completion overrides the FLUSH transition taken in the same cycle.
        if (bit_take) begin
          if (desc_mode && skip_cnt != 16'd0) begin
            skip_cnt <= skip_cnt - 16'd1;
          end else begin
            out_cnt <= out_cnt + 32'd1;
            fill    <= fill + 3'd1;
            if (last_bit || fill == 3'd7) begin
              byte_out        <= pack_next;
              byte_out_strobe <= 1'b1;
              pack            <= '0;
            end else begin
              pack <= pack_next;
            end
            if (last_bit) begin
              state <= ST_IDLE;
              done  <= 1'b1;
              fill  <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_stream_ctrl.sv
// tb/tb_viterbi_stream_ctrl.sv - randomized self-checking bench for viterbi_stream_ctrl
module tb_viterbi_stream_ctrl;

  localparam int SOFT_W     = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int SKIP_BITS  = 9;

  logic        clock = 1'b0;
  logic        reset, enable, start, do_descramble;
  logic [31:0] num_bits_to_decode;
  logic [5:0]  in_data;
  logic [1:0]  in_erase;
  logic        in_valid, in_ready;
  logic [15:0] vit_tdata;
  logic [7:0]  vit_tuser;
  logic        vit_tvalid, vit_tready;
  logic        dec_bit, dec_bit_valid, desc_bit, desc_bit_valid;
  logic [7:0]  byte_out;
  logic        byte_out_strobe, busy, done, overflow;

  viterbi_stream_ctrl #(
    .SOFT_W(SOFT_W), .FIFO_DEPTH(FIFO_DEPTH), .SKIP_BITS(SKIP_BITS)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .num_bits_to_decode(num_bits_to_decode), .do_descramble(do_descramble),
    .in_data(in_data), .in_erase(in_erase), .in_valid(in_valid), .in_ready(in_ready),
    .vit_tdata(vit_tdata), .vit_tuser(vit_tuser), .vit_tvalid(vit_tvalid), .vit_tready(vit_tready),
    .dec_bit(dec_bit), .dec_bit_valid(dec_bit_valid), .desc_bit(desc_bit), .desc_bit_valid(desc_bit_valid),
    .byte_out(byte_out), .byte_out_strobe(byte_out_strobe), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  got_bytes[$];
  logic [17:0] got_pairs[$];
  int          done_cnt, bytes_at_done, stall_viol;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_tdata;
  logic [7:0]  prev_tuser;
  logic [7:0]  tx_pairs[$];
  logic        tx_bits[$];
  logic [7:0]  exp_bytes[$];

  always @(negedge clock) begin
    if (byte_out_strobe) got_bytes.push_back(byte_out);
    if (done) begin
      done_cnt++;
      bytes_at_done = got_bytes.size();
    end
    if (vit_tvalid && vit_tready) got_pairs.push_back({vit_tuser[1:0], vit_tdata});
    if (prev_stall && !(vit_tvalid && vit_tdata === prev_tdata && vit_tuser === prev_tuser)) stall_viol++;
    prev_stall = vit_tvalid && !vit_tready && !reset && !start;
    prev_tdata = vit_tdata;
    prev_tuser = vit_tuser;
  end

  function automatic logic [17:0] exp_pair(input logic [7:0] p);
    return {p[7:6], 5'b0, p[5:3], 5'b0, p[2:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_bytes(input int skip, input int n);
    logic [7:0] cur;
    cur = 8'h00;
    exp_bytes.delete();
    for (int i = 0; i < n; i++) begin
      cur[i % 8] = tx_bits[skip + i];
      if (i % 8 == 7 || i == n - 1) begin
        exp_bytes.push_back(cur);
        cur = 8'h00;
      end
    end
  endtask

  task automatic rand_pairs(input int n);
    tx_pairs.delete();
    for (int i = 0; i < n; i++) tx_pairs.push_back(8'($urandom));
  endtask

  task automatic do_start(input logic [31:0] n, input logic d);
    got_bytes.delete();
    got_pairs.delete();
    done_cnt = 0;
    bytes_at_done = -1;
    stall_viol = 0;
    start = 1'b1;
    num_bits_to_decode = n;
    do_descramble = d;
    tick();
    start = 1'b0;
  endtask

  task automatic send_pairs(input int n, input bit rand_ready, output int sent);
    int cyc;
    sent = 0;
    cyc = 0;
    while (sent < n && cyc < 1000) begin
      in_valid = 1'b1;
      in_data  = tx_pairs[sent][5:0];
      in_erase = tx_pairs[sent][7:6];
      if (rand_ready) vit_tready = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic feed_bits(input bit desc);
    for (int i = 0; i < tx_bits.size(); i++) begin
      if (desc) begin
        desc_bit_valid = 1'b1; desc_bit = tx_bits[i];
        dec_bit_valid  = 1'b1; dec_bit  = 1'b1;
      end else begin
        dec_bit_valid  = 1'b1; dec_bit  = tx_bits[i];
        desc_bit_valid = 1'($urandom_range(0, 1)); desc_bit = 1'b1;
      end
      tick();
    end
    dec_bit_valid = 1'b0;
    desc_bit_valid = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (done_cnt == 0 && c < 300) begin
      @(negedge clock);
      c++;
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    @(negedge clock);
    n_checks++;
    if ({vit_tvalid, in_ready, byte_out_strobe, busy, done, overflow} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000", {vit_tvalid, in_ready, byte_out_strobe, busy, done, overflow});
    else n_pass++;
    n_checks++;
    if ({vit_tdata, vit_tuser, byte_out} !== 32'h0)
      $display("FAIL reset_data: got %h expected 0", {vit_tdata, vit_tuser, byte_out});
    else n_pass++;
    tick();
    reset = 1'b0;
    tick();
    @(negedge clock);
    n_checks++;
    if ({busy, in_ready, vit_tvalid} !== 3'b000)
      $display("FAIL reset_idle: got %b expected 000", {busy, in_ready, vit_tvalid});
    else n_pass++;
    tick();
  endtask

  task automatic test_basic();
    int sent;
    rand_pairs(24);
    vit_tready = 1'b1;
    do_start(48, 1'b0);
    send_pairs(24, 1'b0, sent);
    tx_bits.delete();
    for (int i = 0; i < 48; i++) tx_bits.push_back((8'hA5 >> (i % 8)) & 8'h01);
    feed_bits(1'b0);
    wait_done();
    n_checks++;
    if (got_pairs.size() < 24) $display("FAIL basic_pair_count: got %0d expected >=24", got_pairs.size());
    else begin
      n_pass++;
      for (int i = 0; i < 24; i++) begin
        n_checks++;
        if (got_pairs[i] !== exp_pair(tx_pairs[i]))
          $display("FAIL basic_pair[%0d]: got %h expected %h", i, got_pairs[i], exp_pair(tx_pairs[i]));
        else n_pass++;
      end
    end
    n_checks++;
    if (got_bytes.size() != 6) $display("FAIL basic_byte_count: got %0d expected 6", got_bytes.size());
    else n_pass++;
    for (int i = 0; i < got_bytes.size() && i < 6; i++) begin
      n_checks++;
      if (got_bytes[i] !== 8'hA5) $display("FAIL basic_byte[%0d]: got %h expected a5", i, got_bytes[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_cnt != 1 || bytes_at_done != 6)
      $display("FAIL basic_done: got done=%0d bytes_at_done=%0d expected 1/6", done_cnt, bytes_at_done);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL basic_busy: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_stall();
    int sent, c;
    rand_pairs(20);
    do_start(40, 1'b0);
    send_pairs(20, 1'b1, sent);
    c = 0;
    while (got_pairs.size() < 20 && c < 500) begin
      vit_tready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    vit_tready = 1'b1;
    tx_bits.delete();
    for (int i = 0; i < 40; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    model_bytes(0, 40);
    feed_bits(1'b0);
    wait_done();
    n_checks++;
    if (got_pairs.size() < 20) $display("FAIL stall_pair_count: got %0d expected >=20", got_pairs.size());
    else begin
      n_pass++;
      for (int i = 0; i < 20; i++) begin
        n_checks++;
        if (got_pairs[i] !== exp_pair(tx_pairs[i]))
          $display("FAIL stall_pair[%0d]: got %h expected %h", i, got_pairs[i], exp_pair(tx_pairs[i]));
        else n_pass++;
      end
    end
    n_checks++;
    if (stall_viol != 0) $display("FAIL stall_stable: got %0d changes expected 0", stall_viol);
    else n_pass++;
    n_checks++;
    if (got_bytes.size() != exp_bytes.size())
      $display("FAIL stall_byte_count: got %0d expected %0d", got_bytes.size(), exp_bytes.size());
    else n_pass++;
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
      n_checks++;
      if (got_bytes[i] !== exp_bytes[i]) $display("FAIL stall_byte[%0d]: got %h expected %h", i, got_bytes[i], exp_bytes[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_cnt != 1) $display("FAIL stall_done: got %0d expected 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [5:0] rdy;
    rand_pairs(6);
    vit_tready = 1'b0;
    do_start(1000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = tx_pairs[i][5:0];
      in_erase = tx_pairs[i][7:6];
      @(negedge clock);
      rdy[i] = in_ready;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (rdy !== 6'b001111) $display("FAIL ovf_ready: got %b expected 001111", rdy);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow);
    else n_pass++;
    n_checks++;
    if (got_pairs.size() != 0) $display("FAIL ovf_held: got %0d transfers expected 0", got_pairs.size());
    else n_pass++;
    tick();
    vit_tready = 1'b1;
    repeat (8) tick();
    @(negedge clock);
    n_checks++;
    if (got_pairs.size() != 4) $display("FAIL ovf_fwd_count: got %0d expected 4", got_pairs.size());
    else n_pass++;
    for (int i = 0; i < got_pairs.size() && i < 4; i++) begin
      n_checks++;
      if (got_pairs[i] !== exp_pair(tx_pairs[i]))
        $display("FAIL ovf_pair[%0d]: got %h expected %h", i, got_pairs[i], exp_pair(tx_pairs[i]));
      else n_pass++;
    end
    n_checks++;
    if ({overflow, vit_tvalid, stall_viol == 0} !== 3'b101)
      $display("FAIL ovf_after: got %b expected 101", {overflow, vit_tvalid, stall_viol == 0});
    else n_pass++;
    tick();
  endtask

  task automatic test_descramble();
    vit_tready = 1'b1;
    do_start(16, 1'b1);
    tx_bits.delete();
    for (int i = 0; i < 25; i++) tx_bits.push_back(i < 9);
    model_bytes(SKIP_BITS, 16);
    feed_bits(1'b1);
    wait_done();
    n_checks++;
    if (got_bytes.size() != 2) $display("FAIL desc_byte_count: got %0d expected 2", got_bytes.size());
    else n_pass++;
    for (int i = 0; i < got_bytes.size() && i < 2; i++) begin
      n_checks++;
      if (got_bytes[i] !== exp_bytes[i]) $display("FAIL desc_byte[%0d]: got %h expected %h", i, got_bytes[i], exp_bytes[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_cnt != 1 || got_pairs.size() != 0)
      $display("FAIL desc_done: got done=%0d pairs=%0d expected 1/0", done_cnt, got_pairs.size());
    else n_pass++;
  endtask

  task automatic test_flush();
    int sent;
    int bad;
    vit_tready = 1'b1;
    do_start(8, 1'b0);
    @(negedge clock);
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL flush_ovf_clear: got %b expected 0", overflow);
    else n_pass++;
    rand_pairs(4);
    tick();
    send_pairs(4, 1'b0, sent);
    repeat (3) tick();
    got_pairs.delete();
    @(negedge clock);
    n_checks++;
    if ({vit_tvalid, vit_tdata, vit_tuser} !== {1'b1, 16'h0303, 8'h00})
      $display("FAIL flush_neutral: got %b/%h/%h expected 1/0303/00", vit_tvalid, vit_tdata, vit_tuser);
    else n_pass++;
    tick();
    rand_pairs(3);
    send_pairs(3, 1'b0, sent);
    n_checks++;
    if (sent != 3) $display("FAIL flush_accept: got %0d expected 3", sent);
    else n_pass++;
    tx_bits.delete();
    for (int i = 0; i < 8; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    model_bytes(0, 8);
    feed_bits(1'b0);
    wait_done();
    bad = 0;
    foreach (got_pairs[i]) if (got_pairs[i] !== 18'h00303) bad++;
    n_checks++;
    if (bad != 0 || got_pairs.size() == 0)
      $display("FAIL flush_fwd: got %0d non-neutral of %0d expected 0", bad, got_pairs.size());
    else n_pass++;
    n_checks++;
    if (got_bytes.size() != 1 || got_bytes[0] !== exp_bytes[0] || done_cnt != 1)
      $display("FAIL flush_byte: got n=%0d b=%h done=%0d expected 1/%h/1", got_bytes.size(),
               (got_bytes.size() > 0) ? got_bytes[0] : 8'h00, done_cnt, exp_bytes[0]);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int sent;
    vit_tready = 1'b0;
    rand_pairs(3);
    do_start(16, 1'b0);
    send_pairs(3, 1'b0, sent);
    tx_bits.delete();
    for (int i = 0; i < 5; i++) tx_bits.push_back(1'b1);
    feed_bits(1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({busy, in_ready, vit_tvalid} !== 3'b000)
      $display("FAIL midrst_idle: got %b expected 000", {busy, in_ready, vit_tvalid});
    else n_pass++;
    vit_tready = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (got_bytes.size() != 0 || done_cnt != 0)
      $display("FAIL midrst_residual: got bytes=%0d done=%0d expected 0/0", got_bytes.size(), done_cnt);
    else n_pass++;
    rand_pairs(8);
    do_start(16, 1'b0);
    send_pairs(8, 1'b0, sent);
    tx_bits.delete();
    for (int i = 0; i < 16; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    model_bytes(0, 16);
    feed_bits(1'b0);
    wait_done();
    n_checks++;
    if (got_pairs.size() < 8 || got_pairs[0] !== exp_pair(tx_pairs[0]) || got_pairs[7] !== exp_pair(tx_pairs[7]))
      $display("FAIL midrst_pairs: got n=%0d first=%h expected %h", got_pairs.size(),
               (got_pairs.size() > 0) ? got_pairs[0] : 18'h0, exp_pair(tx_pairs[0]));
    else n_pass++;
    n_checks++;
    if (got_bytes.size() != 2 || got_bytes[0] !== exp_bytes[0] || got_bytes[1] !== exp_bytes[1])
      $display("FAIL midrst_bytes: got n=%0d expected %h %h", got_bytes.size(), exp_bytes[0], exp_bytes[1]);
    else n_pass++;
  endtask

  task automatic test_zero_bits();
    vit_tready = 1'b1;
    do_start(0, 1'b0);
    @(negedge clock);
    n_checks++;
    if ({done, busy} !== 2'b10) $display("FAIL zero_done: got %b expected 10", {done, busy});
    else n_pass++;
    repeat (5) tick();
    n_checks++;
    if (got_pairs.size() != 0 || got_bytes.size() != 0 || done_cnt != 1)
      $display("FAIL zero_quiet: got pairs=%0d bytes=%0d done=%0d expected 0/0/1",
               got_pairs.size(), got_bytes.size(), done_cnt);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0; num_bits_to_decode = '0; do_descramble = 1'b0;
    in_data = '0; in_erase = '0; in_valid = 1'b0; vit_tready = 1'b0;
    dec_bit = 1'b0; dec_bit_valid = 1'b0; desc_bit = 1'b0; desc_bit_valid = 1'b0;
    done_cnt = 0; bytes_at_done = -1; stall_viol = 0;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_descramble();
    test_flush();
    test_mid_reset();
    test_zero_bits();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
